tart_aq_stream: RTL and testbench

- Parametrised successor to the TART acquisition control slave.
- Serialises ANTENNAS-bit antenna samples into WIDTH-bit bytes for the SPI bus. Samples come from a DEPTH-entry prefetch FIFO, which is refilled from DRAM through a request/ready handshake.
- Adds FIFO-level, byte-index and sticky-underflow reporting behind the same Wishbone-like register port.
- Sits between the SPI slave bus and the DRAM reader.

---
 rtl/tart_aq_pkg.sv | 22 ++
 rtl/tart_aq_fifo.sv | 65 ++++++
 rtl/tart_aq_stream.sv | 180 ++++++++++++++++++
 tb/tb_tart_aq_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tart_aq_pkg.sv
// Shared definitions for the TART acquisition stream block: register map,
// status bit positions and the prefetch state encoding.
package tart_aq_pkg;

    localparam logic [2:0] AQ_STREAM = 3'd0;
    localparam logic [2:0] AQ_LEVEL  = 3'd1;
    localparam logic [2:0] AQ_INDEX  = 3'd2;
    localparam logic [2:0] AQ_DELAY  = 3'd5;
    localparam logic [2:0] AQ_DEBUG  = 3'd6;
    localparam logic [2:0] AQ_STATUS = 3'd7;

    localparam int ST_ENABLED   = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_FULL      = 3;

    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_WAIT = 1'b1
    } pf_state_e;

endpackage

// File: rtl/tart_aq_fifo.sv
// Small synchronous prefetch FIFO with a combinational head output and an
// explicit fill level; pointers wrap naturally at the power-of-two depth.
module tart_aq_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == DEPTH_L);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; the level alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tart_aq_stream.sv
// TART acquisition stream slave: serialises prefetched antenna samples into
// bus bytes and keeps the prefetch FIFO topped up from DRAM.
module tart_aq_stream
    import tart_aq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ANTENNAS = 24,
    parameter int BYTES    = ANTENNAS / WIDTH,
    parameter int DEPTH    = 4,
    parameter int DELAY    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    output logic                ack_o,
    input  logic [2:0]          adr_i,
    input  logic [WIDTH-1:0]    dat_i,
    output logic [WIDTH-1:0]    dat_o,
    input  logic                data_ready,
    output logic                data_request,
    input  logic [ANTENNAS-1:0] data_in,
    input  logic                spi_busy,
    output logic                aq_debug_mode,
    output logic                aq_enabled,
    output logic [2:0]          aq_sample_delay
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LW:0] DEPTH_CMP = (LW + 1)'(DEPTH);

    if (((ANTENNAS % WIDTH) != 0) || (WIDTH < 4) || (DELAY < 0)) begin : g_bad_params
        $error("tart_aq_stream: unsupported parameter set");
    end

    logic                 ack_q;
    logic [WIDTH-1:0]     dat_q, rd_data;
    logic                 req_q, req_d;
    logic                 enabled_q, enabled_d;
    logic                 debug_q, debug_d;
    logic [2:0]           delay_q, delay_d;
    logic                 underflow_q, underflow_d;
    logic [IW-1:0]        index_q, index_d;
    pf_state_e            state_q, state_d;

    logic                 read_stb, write_stb, stream_rd, last_byte;
    logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [ANTENNAS-1:0]  fifo_head, head_shifted;
    logic [LW-1:0]        fifo_level;
    logic [LW:0]          fill_sum;
    logic [WIDTH-1:0]     head_byte;
    logic                 dat_i_unused;

    assign dat_i_unused = ^dat_i[WIDTH-1:3];

    assign read_stb  = cyc_i & stb_i & ~we_i & ~ack_q;
    assign write_stb = cyc_i & stb_i &  we_i & ~ack_q;
    assign stream_rd = read_stb & (adr_i == AQ_STREAM);
    assign last_byte = (index_q == IW'(BYTES - 1));

    // A low spi_busy restarts the sample and blocks the pop of a final-byte read.
    assign fifo_pop  = spi_busy & stream_rd & ~fifo_empty & last_byte;

    assign head_shifted = fifo_head >> (WIDTH * (BYTES - 1 - int'(index_q)));
    assign head_byte    = head_shifted[WIDTH-1:0];
    assign fill_sum     = {1'b0, fifo_level} + (LW + 1)'(fifo_pop);

    tart_aq_fifo #(
        .WIDTH (ANTENNAS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (data_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            PF_IDLE: begin
                if (enabled_q && (fill_sum < DEPTH_CMP)) begin
                    state_d = PF_WAIT;
                    req_d   = 1'b1;
                end
            end
            PF_WAIT: begin
                if (data_ready) begin
                    state_d   = PF_IDLE;
                    fifo_push = 1'b1;
                end
            end
            default: state_d = PF_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (adr_i)
            AQ_STREAM: rd_data = fifo_empty ? '0 : head_byte;
            AQ_LEVEL:  rd_data = WIDTH'(fifo_level);
            AQ_INDEX:  rd_data = WIDTH'(index_q);
            AQ_DELAY:  rd_data = WIDTH'(delay_q);
            AQ_DEBUG:  rd_data = WIDTH'(debug_q);
            AQ_STATUS: begin
                rd_data[ST_ENABLED]   = enabled_q;
                rd_data[ST_UNDERFLOW] = underflow_q;
                rd_data[ST_EMPTY]     = fifo_empty;
                rd_data[ST_FULL]      = fifo_full;
            end
            default:   rd_data = '0;
        endcase
    end

    always_comb begin
        enabled_d   = enabled_q;
        debug_d     = debug_q;
        delay_d     = delay_q;
        underflow_d = underflow_q;
        index_d     = index_q;
        if (write_stb) begin
            case (adr_i)
                AQ_DELAY:  delay_d = dat_i[2:0];
                AQ_DEBUG:  debug_d = dat_i[0];
                AQ_STATUS: begin
                    enabled_d = dat_i[ST_ENABLED];
                    if (dat_i[ST_UNDERFLOW]) underflow_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (stream_rd && fifo_empty) underflow_d = 1'b1;
        if (!spi_busy) begin
            index_d = '0;
        end else if (stream_rd && !fifo_empty) begin
            index_d = last_byte ? '0 : index_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            req_q       <= 1'b0;
            enabled_q   <= 1'b0;
            debug_q     <= 1'b0;
            delay_q     <= '0;
            underflow_q <= 1'b0;
            index_q     <= '0;
            state_q     <= PF_IDLE;
        end else begin
            ack_q       <= cyc_i & stb_i & ~ack_q;
            if (read_stb) dat_q <= rd_data;
            req_q       <= req_d;
            enabled_q   <= enabled_d;
            debug_q     <= debug_d;
            delay_q     <= delay_d;
            underflow_q <= underflow_d;
            index_q     <= index_d;
            state_q     <= state_d;
        end
    end

    assign ack_o           = ack_q;
    assign dat_o           = dat_q;
    assign data_request    = req_q;
    assign aq_enabled      = enabled_q;
    assign aq_debug_mode   = debug_q;
    assign aq_sample_delay = delay_q;

endmodule

// File: tb/tb_tart_aq_stream.sv
// Directed bench for tart_aq_stream: register map, prefetch fill, byte
// streaming, spi_busy index restart, underflow and asynchronous reset.
module tb_tart_aq_stream;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic        ack_o;
    logic [2:0]  adr_i = '0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        data_ready = 1'b0;
    logic        data_request;
    logic [23:0] data_in = '0;
    logic        spi_busy = 1'b0;
    logic        aq_debug_mode;
    logic        aq_enabled;
    logic [2:0]  aq_sample_delay;

    int checks = 0;
    int errors = 0;
    int req_count = 0;
    int word_idx = 0;
    logic resp_en = 1'b0;
    logic [7:0] rd;
    logic seen;

    logic [23:0] words [8] = '{24'hA1B2C3, 24'hD4E5F6, 24'h071829, 24'h3A4B5C,
                               24'h6D7E8F, 24'h90A1B2, 24'hC3D4E5, 24'hF60718};
    logic [7:0] exp_drain [12] = '{8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29,
                                   8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F};

    always #5 clk_i = ~clk_i;

    tart_aq_stream dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cyc_i           (cyc_i),
        .stb_i           (stb_i),
        .we_i            (we_i),
        .ack_o           (ack_o),
        .adr_i           (adr_i),
        .dat_i           (dat_i),
        .dat_o           (dat_o),
        .data_ready      (data_ready),
        .data_request    (data_request),
        .data_in         (data_in),
        .spi_busy        (spi_busy),
        .aq_debug_mode   (aq_debug_mode),
        .aq_enabled      (aq_enabled),
        .aq_sample_delay (aq_sample_delay)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access; inputs change on the falling edge, ack is bounded.
    task automatic bus(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                       output logic [7:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = wr; adr_i = a; dat_i = wd;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                got   = 1'b1;
                rdata = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        check("ack", {31'b0, got}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus(1'b0, a, 8'h00, v);
        check(tag, {24'b0, v}, {24'b0, exp});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] v;
        bus(1'b1, a, d, v);
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (data_request) req_count++;
        end
    end

    // DRAM model: answer each request one cycle later with the next word.
    initial begin
        forever begin
            @(negedge clk_i);
            if (resp_en && data_request) begin
                @(negedge clk_i);
                data_ready = 1'b1;
                data_in    = words[word_idx];
                word_idx++;
                @(negedge clk_i);
                data_ready = 1'b0;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        check("rst_ack", {31'b0, ack_o}, 32'd0);
        check("rst_dat", {24'b0, dat_o}, 32'd0);
        check("rst_req", {31'b0, data_request}, 32'd0);
        check("rst_aq", {27'b0, aq_enabled, aq_debug_mode, aq_sample_delay}, 32'd0);
        rd_chk("status_reset", 3'd7, 8'h04);
        rd_chk("level_reset", 3'd1, 8'h00);
        repeat (20) @(negedge clk_i);
        check("no_req_disabled", req_count, 32'd0);

        resp_en = 1'b1;
        wr(3'd7, 8'h01);
        check("enabled", {31'b0, aq_enabled}, 32'd1);
        repeat (40) @(negedge clk_i);
        check("fill_requests", req_count, 32'd4);
        rd_chk("level_full", 3'd1, 8'h04);
        rd_chk("status_full", 3'd7, 8'h09);

        spi_busy = 1'b1;
        @(negedge clk_i);
        rd_chk("byte0", 3'd0, 8'hA1);
        rd_chk("index1", 3'd2, 8'h01);
        rd_chk("byte1", 3'd0, 8'hB2);
        rd_chk("byte2", 3'd0, 8'hC3);
        rd_chk("level_after_pop", 3'd1, 8'h03);
        rd_chk("index_wrap", 3'd2, 8'h00);
        repeat (20) @(negedge clk_i);
        check("refill_request", req_count, 32'd5);
        rd_chk("level_refilled", 3'd1, 8'h04);

        wr(3'd7, 8'h00);
        check("disabled", {31'b0, aq_enabled}, 32'd0);

        rd_chk("resend_first", 3'd0, 8'hD4);
        spi_busy = 1'b0;
        @(negedge clk_i);
        spi_busy = 1'b1;
        rd_chk("index_cleared", 3'd2, 8'h00);
        rd_chk("level_no_pop", 3'd1, 8'h04);

        for (int i = 0; i < 12; i++) begin
            rd_chk($sformatf("drain%0d", i), 3'd0, exp_drain[i]);
        end
        rd_chk("level_drained", 3'd1, 8'h00);
        rd_chk("underflow_read", 3'd0, 8'h00);
        rd_chk("index_hold_empty", 3'd2, 8'h00);
        rd_chk("status_underflow", 3'd7, 8'h06);
        wr(3'd7, 8'h02);
        rd_chk("status_cleared", 3'd7, 8'h04);
        check("still_disabled", {31'b0, aq_enabled}, 32'd0);
        check("no_req_while_off", req_count, 32'd5);

        wr(3'd5, 8'hFD);
        check("delay_out", {29'b0, aq_sample_delay}, 32'd5);
        rd_chk("delay_reg", 3'd5, 8'h05);
        wr(3'd6, 8'h01);
        check("debug_out", {31'b0, aq_debug_mode}, 32'd1);
        rd_chk("debug_reg", 3'd6, 8'h01);
        wr(3'd3, 8'hFF);
        rd_chk("unmapped", 3'd3, 8'h00);

        resp_en = 1'b0;
        wr(3'd7, 8'h01);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (data_request) seen = 1'b1;
            else @(negedge clk_i);
        end
        check("req_before_reset", {31'b0, seen}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_ack", {31'b0, ack_o}, 32'd0);
        check("arst_dat", {24'b0, dat_o}, 32'd0);
        check("arst_req", {31'b0, data_request}, 32'd0);
        check("arst_aq", {27'b0, aq_enabled, aq_debug_mode, aq_sample_delay}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        data_ready = 1'b1;
        data_in    = 24'hFFFFFF;
        @(negedge clk_i);
        data_ready = 1'b0;
        @(negedge clk_i);
        rd_chk("late_ready_level", 3'd1, 8'h00);
        rd_chk("late_ready_status", 3'd7, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
